// File: rtl/deser_pkg.sv
// Shared definitions for the aligned serial-to-parallel deserializer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the alignment FSM state encoding, the state and counter widths,
// and the default alignment (comma) word.
package deser_pkg;

    localparam int STATE_W = 2;

    // Counters only need to reach 15 (largest LOCK_COUNT / LOSS_COUNT).
    localparam int CNT_W = 4;

    typedef enum logic [STATE_W-1:0] {
        SEARCH   = 2'd0,
        ALIGNING = 2'd1,
        LOCKED   = 2'd2
    } deser_state_e;

    localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

endpackage

// File: rtl/deser_fsm.sv
// Word-alignment FSM: hunts for the comma, confirms LOCK_COUNT aligned commas, then tracks lock.
// Latency: decision strobes are combinational on the current sample; state updates on that edge.
// Backpressure: none; one bit arrives every clock and must be consumed.
//
// Ports:
//   clk_i, rst_ni   clock and asynchronous active-low reset
//   match_i         the window including this edge's bit equals the comma
//   boundary_i      this edge completes a word at the current alignment
//   sync_o          restart the word boundary here (comma found while searching)
//   lock_o          lock acquired on this edge
//   unlock_o        lock lost on this edge (only with DESER_RELOCK_EN)
//   emit_o          this edge completes a non-comma data word while locked
//
// Optional feature: define DESER_RELOCK_EN to drop lock after LOSS_COUNT
// consecutive word intervals that each contained a comma at the wrong offset.
module deser_fsm
    import deser_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic match_i,
    input  logic boundary_i,
    output logic sync_o,
    output logic lock_o,
    output logic unlock_o,
    output logic emit_o
);

    deser_state_e     state_q;
    logic [CNT_W-1:0] comma_cnt_q;
    logic             go_lock;
    logic             lose;

`ifdef DESER_RELOCK_EN
    logic [CNT_W-1:0] mis_cnt_q;
    logic             mis_seen_q;   // a comma appeared off-boundary in the current interval

    assign lose = (state_q == LOCKED) && boundary_i && mis_seen_q &&
                  (mis_cnt_q == CNT_W'(LOSS_COUNT - 1));
`else
    // Lock can only be left through reset in this build; the term is
    // constant false for every legal LOSS_COUNT.
    assign lose = (LOSS_COUNT < 1) && 1'b0;
`endif

    assign go_lock  = (state_q == ALIGNING) && boundary_i && match_i &&
                      (comma_cnt_q == CNT_W'(LOCK_COUNT - 1));
    assign sync_o   = (state_q == SEARCH) && match_i;
    assign lock_o   = go_lock;
    assign unlock_o = lose;
    // A data word landing on the same edge as loss of lock is not trusted.
    assign emit_o   = (state_q == LOCKED) && boundary_i && !match_i && !lose;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= SEARCH;
            comma_cnt_q <= '0;
`ifdef DESER_RELOCK_EN
            mis_cnt_q   <= '0;
            mis_seen_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                SEARCH: begin
                    if (match_i) begin
                        comma_cnt_q <= CNT_W'(1);
                        state_q     <= ALIGNING;
                    end
                end
                ALIGNING: begin
                    if (boundary_i) begin
                        if (match_i) begin
                            comma_cnt_q <= comma_cnt_q + 1'b1;
                            if (go_lock) begin
                                state_q <= LOCKED;
                            end
                        end else begin
                            comma_cnt_q <= '0;
                            state_q     <= SEARCH;
                        end
                    end
                end
                LOCKED: begin
`ifdef DESER_RELOCK_EN
                    if (boundary_i) begin
                        mis_seen_q <= 1'b0;
                        if (lose) begin
                            state_q     <= SEARCH;
                            comma_cnt_q <= '0;
                            mis_cnt_q   <= '0;
                        end else if (mis_seen_q) begin
                            mis_cnt_q <= mis_cnt_q + 1'b1;
                        end else begin
                            mis_cnt_q <= '0;
                        end
                    end else if (match_i) begin
                        mis_seen_q <= 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= SEARCH;
                end
            endcase
        end
    end

endmodule

// File: rtl/deserializador_alineado.sv
// Aligned serial-to-parallel deserializer: MSB-first bits in, comma-aligned WIDTH-bit words out.
// Latency: data_out/valid_out update on the same edge that samples the last bit of a word.
// Backpressure: none; valid_out is a one-cycle strobe and the consumer must take it.
//
// Ports:
//   clk_32f    bit clock, rising edge
//   reset_L    asynchronous active-low reset
//   data_in    serial data, one bit per edge, MSB first
//   data_out   last received non-comma word (held between strobes)
//   valid_out  data_out was updated on this edge
//   active     high while word alignment is locked
//
// Optional feature: define DESER_RELOCK_EN so a locked link that keeps seeing
// commas at the wrong offset falls back to searching.
module deserializador_alineado
    import deser_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(COMMA_DEFAULT),
    parameter int               LOCK_COUNT = 4,
    parameter int               LOSS_COUNT = 3
) (
    input  logic             clk_32f,
    input  logic             reset_L,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active
);

    localparam int BCW = $clog2(WIDTH);

    logic [WIDTH-1:0] window_q, window_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             active_q, active_d;

    logic match;
    logic boundary;
    logic sync;
    logic lock;
    logic unlock;
    logic emit;

    // Decisions look at the window including the bit sampled on this edge,
    // which is what gives zero-edge latency after a word's last bit.
    assign window_d = {window_q[WIDTH-2:0], data_in};
    assign match    = (window_d == COMMA);
    assign boundary = (bit_cnt_q == BCW'(WIDTH - 1));

    deser_fsm #(
        .LOCK_COUNT (LOCK_COUNT),
        .LOSS_COUNT (LOSS_COUNT)
    ) u_fsm (
        .clk_i      (clk_32f),
        .rst_ni     (reset_L),
        .match_i    (match),
        .boundary_i (boundary),
        .sync_o     (sync),
        .lock_o     (lock),
        .unlock_o   (unlock),
        .emit_o     (emit)
    );

    always_comb begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        // A comma found while searching defines the boundary on this edge.
        if (sync || boundary) begin
            bit_cnt_d = '0;
        end

        data_d  = emit ? window_d : data_q;
        valid_d = emit;

        active_d = active_q;
        if (lock) begin
            active_d = 1'b1;
        end else if (unlock) begin
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            window_q  <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            window_q  <= window_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = active_q;

endmodule

// File: tb/tb_deserializador_alineado.sv
// Directed bench for deserializador_alineado (WIDTH=8, default parameters).
// Expected words are queued with the edge number they must appear on; every
// edge checks valid_out against the queue and data_out against the held value.
module tb_deserializador_alineado;

    localparam int W = 8;
    localparam logic [W-1:0] BC = 8'hBC;

`ifdef DESER_RELOCK_EN
    localparam bit RELOCK = 1'b1;
`else
    localparam bit RELOCK = 1'b0;
`endif

    logic         clk_32f = 1'b0;
    logic         reset_L = 1'b1;
    logic         data_in = 1'b0;
    logic [W-1:0] data_out;
    logic         valid_out;
    logic         active;

    typedef struct packed {
        int           e;
        logic [W-1:0] d;
    } exp_t;

    exp_t         sb[$];
    int           edge_n    = 0;
    logic [W-1:0] last_data = '0;
    int           n_tests   = 0;
    int           n_fail    = 0;

    deserializador_alineado #(
        .WIDTH      (W),
        .COMMA      (BC),
        .LOCK_COUNT (4),
        .LOSS_COUNT (3)
    ) dut (
        .clk_32f   (clk_32f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (edge %0d): observed %0h expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic expect_word(input int e, input logic [W-1:0] d);
        exp_t t;
        t.e = e;
        t.d = d;
        sb.push_back(t);
    endtask

    // Drive one bit, let one rising edge pass, then check the outputs.
    task automatic send_bit(input logic b);
        exp_t x;
        logic exp_v;
        data_in = b;
        @(posedge clk_32f);
        #1;
        edge_n++;
        exp_v = (sb.size() > 0) && (sb[0].e == edge_n);
        check("valid_out", {31'd0, valid_out}, {31'd0, exp_v});
        if (exp_v) begin
            x = sb.pop_front();
            check("data_out", {24'd0, data_out}, {24'd0, x.d});
            last_data = x.d;
        end else begin
            check("data_hold", {24'd0, data_out}, {24'd0, last_data});
        end
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(v[i]);
        end
    endtask

    task automatic send_word(input logic [W-1:0] w);
        send_bits({8'd0, w}, W);
    endtask

    // Assert reset mid-cycle, confirm outputs clear before any edge,
    // optionally hold it over random data, then release.
    task automatic do_reset(input int cycles);
        reset_L = 1'b0;
        #1;
        check("rst_active", {31'd0, active}, 32'd0);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_data", {24'd0, data_out}, 32'd0);
        sb.delete();
        last_data = '0;
        for (int i = 0; i < cycles; i++) begin
            send_bit(1'($urandom_range(0, 1)));
            check("rst_hold_active", {31'd0, active}, 32'd0);
        end
        #1;
        reset_L = 1'b1;
        edge_n  = 0;
    endtask

    initial begin
        #2;
        do_reset(16);

        // Comma stream at a 3-bit offset: lock on edge 35, 8'h55 on edge 43.
        send_bits(16'd0, 3);
        repeat (3) send_word(BC);
        send_bits({8'd0, BC >> 1}, 7);
        check("lock_edge34", {31'd0, active}, 32'd0);
        send_bits({15'd0, BC[0]}, 1);
        check("lock_edge35", {31'd0, active}, 32'd1);
        expect_word(43, 8'h55);
        send_word(8'h55);
        check("sb_empty_offset", sb.size(), 32'd0);

        do_reset(4);

        // Broken comma run: 8'h12 must reset the count and never be emitted.
        repeat (3) send_word(BC);
        send_word(8'h12);
        check("no_lock_after_12", {31'd0, active}, 32'd0);
        repeat (3) send_word(BC);
        check("no_lock_3_commas", {31'd0, active}, 32'd0);
        send_word(BC);
        check("lock_edge64", {31'd0, active}, 32'd1);
        expect_word(72, 8'hA5);
        send_word(8'hA5);

        // Locked stream A5, BC, 3C: comma word is swallowed, data holds.
        send_word(BC);
        check("hold_a5_on_comma", {24'd0, data_out}, 32'h0000_00A5);
        expect_word(88, 8'h3C);
        send_word(8'h3C);
        check("sb_empty_locked", sb.size(), 32'd0);

        // One extra bit slips the alignment; commas now sit one bit late,
        // so every boundary window reads 8'h5E.
        if (RELOCK) begin
            expect_word(96, 8'h5E);
            expect_word(104, 8'h5E);
            expect_word(112, 8'h5E);
            expect_word(153, 8'hA5);
        end else begin
            for (int k = 0; k < 7; k++) expect_word(96 + 8 * k, 8'h5E);
            expect_word(152, 8'h52);
        end
        send_bit(1'b0);
        repeat (3) send_word(BC);
        send_bits({8'd0, BC >> 2}, 6);
        check("slip_edge119", {31'd0, active}, 32'd1);
        send_bit(BC[1]);
        check("slip_edge120", {31'd0, active}, RELOCK ? 32'd0 : 32'd1);
        send_bit(BC[0]);
        repeat (2) send_word(BC);
        send_bits({8'd0, BC >> 1}, 7);
        check("slip_edge144", {31'd0, active}, RELOCK ? 32'd0 : 32'd1);
        send_bit(BC[0]);
        check("slip_edge145", {31'd0, active}, 32'd1);
        send_word(8'hA5);
        check("sb_empty_slip", sb.size(), 32'd0);

        // Reset pulse mid-word while locked; relock needs four fresh commas.
        check("locked_before_pulse", {31'd0, active}, 32'd1);
        send_bits(16'b101, 3);
        do_reset(0);
        repeat (3) send_word(BC);
        check("no_relock_3_commas", {31'd0, active}, 32'd0);
        send_word(BC);
        check("relock_edge32", {31'd0, active}, 32'd1);
        expect_word(40, 8'h3C);
        send_word(8'h3C);
        check("sb_empty_final", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
